// File: rtl/alu_pkg.sv
// Shared opcode definitions for the ALU datapath.
package alu_pkg;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_ADD   = 4'b0000;
    localparam opcode_t OP_SUB   = 4'b0001;
    localparam opcode_t OP_AND   = 4'b0010;
    localparam opcode_t OP_OR    = 4'b0011;
    localparam opcode_t OP_XOR   = 4'b0100;
    localparam opcode_t OP_NOR   = 4'b0101;
    localparam opcode_t OP_SLL   = 4'b0110;
    localparam opcode_t OP_SRL   = 4'b0111;
    localparam opcode_t OP_SRA   = 4'b1000;
    localparam opcode_t OP_SLT   = 4'b1001;
    localparam opcode_t OP_SLTU  = 4'b1010;
    localparam opcode_t OP_ROL   = 4'b1011;
    localparam opcode_t OP_ROR   = 4'b1100;
    localparam opcode_t OP_NOT   = 4'b1101;
    localparam opcode_t OP_PASSA = 4'b1110;
    localparam opcode_t OP_PASSB = 4'b1111;

endpackage

// File: rtl/alu_shifter.sv
// Combinational shift/rotate unit; non-shift opcodes give zero.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]         a,
    input  logic [$clog2(WIDTH)-1:0] amount,
    input  opcode_t                  op,
    output logic [WIDTH-1:0]         shift_c
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam logic [SHW:0] WIDTH_E = (SHW+1)'(WIDTH);

    logic [SHW:0] amt_ext;
    logic [SHW:0] rot;

    // Rotate amount reduced modulo WIDTH (matters only for non-power-of-two widths)
    always_comb begin
        amt_ext = {1'b0, amount};
        rot     = (amt_ext >= WIDTH_E) ? (amt_ext - WIDTH_E) : amt_ext;
    end

    // Shift/rotate select; a zero rotate shifts the wrapped half fully out
    always_comb begin
        shift_c = '0;
        case (op)
            OP_SLL:  shift_c = a << amount;
            OP_SRL:  shift_c = a >> amount;
            OP_SRA:  shift_c = WIDTH'($signed(a) >>> amount);
            OP_ROL:  shift_c = (a << rot) | (a >> (WIDTH_E - rot));
            OP_ROR:  shift_c = (a >> rot) | (a << (WIDTH_E - rot));
            default: shift_c = '0;
        endcase
    end

endmodule

// File: rtl/alu_core.sv
// Registered integer ALU: result and zero/overflow/carry flags one cycle after in_valid.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  opcode_t          op,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             carry
);

    localparam int unsigned SHW = $clog2(WIDTH);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] shift_c;
    logic [WIDTH-1:0] nxt_result;
    logic             nxt_overflow;
    logic             nxt_carry;

    alu_shifter #(.WIDTH(WIDTH)) u_shifter (
        .a       (a),
        .amount  (b[SHW-1:0]),
        .op      (op),
        .shift_c (shift_c)
    );

    // Extended adder/subtractor; bit WIDTH is carry-out or borrow
    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} - {1'b0, b};
    end

    // Result and flag selection
    always_comb begin
        nxt_result   = '0;
        nxt_overflow = 1'b0;
        nxt_carry    = 1'b0;
        case (op)
            OP_ADD: begin
                nxt_result   = sum[WIDTH-1:0];
                nxt_carry    = sum[WIDTH];
                nxt_overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                nxt_result   = diff[WIDTH-1:0];
                nxt_carry    = ~diff[WIDTH];
                nxt_overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:   nxt_result = a & b;
            OP_OR:    nxt_result = a | b;
            OP_XOR:   nxt_result = a ^ b;
            OP_NOR:   nxt_result = ~(a | b);
            OP_SLT:   nxt_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:  nxt_result = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_NOT:   nxt_result = ~a;
            OP_PASSA: nxt_result = a;
            OP_PASSB: nxt_result = b;
            default:  nxt_result = shift_c;
        endcase
    end

    // Output registers; result and flags hold while in_valid is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            carry     <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result   <= nxt_result;
                zero     <= (nxt_result == '0);
                overflow <= nxt_overflow;
                carry    <= nxt_carry;
            end
        end
    end

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: driver pushes model results, monitor pops and compares.
module tb_alu_core;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        ov;
        logic        cy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    opcode_t     op = OP_ADD;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        carry;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];
    exp_t hold = '{32'h0, 1'b0, 1'b0, 1'b0};

    alu_core #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .carry     (carry)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input opcode_t o);
        exp_t        e;
        longint      sx, sy, ss;
        longint unsigned ux, uy;
        int          k;
        logic [31:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'h0, x});
        uy = longint'({32'h0, y});
        k  = int'(y % 32);
        r  = x;
        e  = '{32'h0, 1'b0, 1'b0, 1'b0};
        case (o)
            OP_ADD: begin
                e.res = 32'(ux + uy);
                e.cy  = (ux + uy) >= 64'h1_0000_0000;
                ss    = sx + sy;
                e.ov  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            OP_SUB: begin
                e.res = 32'(ux - uy);
                e.cy  = ux >= uy;
                ss    = sx - sy;
                e.ov  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            OP_AND:   e.res = x & y;
            OP_OR:    e.res = x | y;
            OP_XOR:   e.res = x ^ y;
            OP_NOR:   e.res = ~(x | y);
            OP_SLL:   e.res = x << k;
            OP_SRL:   e.res = x >> k;
            OP_SRA: begin
                for (int i = 0; i < k; i++) r = {r[31], r[31:1]};
                e.res = r;
            end
            OP_SLT:   e.res = (sx < sy) ? 32'd1 : 32'd0;
            OP_SLTU:  e.res = (ux < uy) ? 32'd1 : 32'd0;
            OP_ROL: begin
                for (int i = 0; i < k; i++) r = {r[30:0], r[31]};
                e.res = r;
            end
            OP_ROR: begin
                for (int i = 0; i < k; i++) r = {r[0], r[31:1]};
                e.res = r;
            end
            OP_NOT:   e.res = ~x;
            OP_PASSA: e.res = x;
            default:  e.res = y;
        endcase
        e.z = (e.res == 32'h0);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive(input logic [31:0] x, input logic [31:0] y, input opcode_t o);
        @(negedge clk);
        a = x; b = y; op = o; in_valid = 1'b1;
        q.push_back(model(x, y, o));
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom; b = $urandom; op = opcode_t'($urandom_range(0, 15));
    endtask

    // Monitor: compares popped expectation when valid, otherwise checks the held values
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (out_valid === 1'b1) begin
                    if (q.size() == 0) begin
                        check("unexpected_out_valid", 32'(out_valid), 32'd0);
                    end else begin
                        e = q.pop_front();
                        check("result", result, e.res);
                        check("zero", 32'(zero), 32'(e.z));
                        check("overflow", 32'(overflow), 32'(e.ov));
                        check("carry", 32'(carry), 32'(e.cy));
                        hold = e;
                    end
                end else begin
                    if (q.size() != 0) begin
                        check("missing_out_valid", 32'(out_valid), 32'd1);
                        void'(q.pop_front());
                    end else begin
                        check("out_valid_low", 32'(out_valid), 32'd0);
                    end
                    check("hold_result", result, hold.res);
                    check("hold_flags", {29'h0, zero, overflow, carry},
                          {29'h0, hold.z, hold.ov, hold.cy});
                end
            end
        end
    end

    // Stimulus
    initial begin
        logic [31:0] x, y;
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_outputs", {result[31:3], result[2:0] | {zero, overflow, carry}}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        drive(32'd5, 32'hFFFFFFFB, OP_SUB);
        drive(32'd5, 32'd5, OP_SUB);
        drive(32'd5, 32'hFFFFFFFB, OP_ADD);
        drive(32'h7FFFFFFF, 32'd1, OP_ADD);
        drive(32'h80000000, 32'd1, OP_SUB);
        drive(32'hFFFFFFFF, 32'd1, OP_ADD);
        drive(32'h80000001, 32'h00000021, OP_SRA);
        drive(32'h80000001, 32'h00000021, OP_ROL);
        drive(32'h80000001, 32'h00000021, OP_SLL);
        drive(32'hFFFFFFFF, 32'd1, OP_SLT);
        drive(32'hFFFFFFFF, 32'd1, OP_SLTU);
        drive(32'd1, 32'd2, OP_ADD);
        drive(32'd6, 32'd3, OP_AND);
        idle();
        idle();

        // Directed spot checks of the plan's literal values through the model
        check("plan_sub_a", model(32'd5, 32'hFFFFFFFB, OP_SUB).res, 32'h0000000A);
        check("plan_sra", model(32'h80000001, 32'h21, OP_SRA).res, 32'hC0000000);
        check("plan_rol", model(32'h80000001, 32'h21, OP_ROL).res, 32'h00000003);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: x = 32'h80000000;
                1: x = 32'h7FFFFFFF;
                default: x = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0: y = x;
                1: y = 32'(-int'(x));
                default: y = $urandom;
            endcase
            if ($urandom_range(0, 4) == 0) idle();
            else drive(x, y, opcode_t'($urandom_range(0, 15)));
        end

        // Reset in the middle of a transaction, away from any clock edge
        drive(32'h12345678, 32'h1, OP_ADD);
        #2;
        rst_n = 1'b0;
        q.delete();
        hold = '{32'h0, 1'b0, 1'b0, 1'b0};
        #1;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_result", result, 32'h0);
        check("midreset_flags", {29'h0, zero, overflow, carry}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        idle();
        drive(32'h0, 32'h0, OP_PASSB);
        idle();
        idle();

        check("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
